// File: rtl/peak_readout_pkg.sv
// Shared constants, types and helpers for the peak readout buffer.
// Frame layout, byte-map addresses and the read-lock FSM state type.
package peak_readout_pkg;

    localparam int PEAKS      = 6;
    localparam int FREQ_WIDTH = 8;
    localparam int AMPL_WIDTH = 24;
    localparam int TIME_WIDTH = 32;

    localparam logic [7:0] ADDR_LOCK   = 8'd0;
    localparam logic [7:0] ADDR_LAST   = 8'd33;
    localparam logic [7:0] ADDR_STATUS = 8'd34;
    localparam logic [7:0] ADDR_DROP   = 8'd35;
    localparam logic [7:0] ADDR_SEQ    = 8'd36;
    localparam logic [7:0] ADDR_ABORT  = 8'd255;
    localparam logic [7:0] SIG_BASE    = 8'd248;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic [TIME_WIDTH-1:0]            counter;
        logic [PEAKS-1:0][FREQ_WIDTH-1:0] freqs;
        logic [PEAKS-1:0][AMPL_WIDTH-1:0] ampls;
    } frame_t;

    localparam int FRAME_W = $bits(frame_t);

    // Fixed signature bytes so software can identify the block.
    function automatic logic [7:0] sig_byte(input logic [2:0] idx);
        logic [7:0] b;
        unique case (idx)
            3'd0: b = 8'd42;
            3'd1: b = 8'd53;
            3'd2: b = 8'd84;
            3'd3: b = 8'd71;
            3'd4: b = 8'd7;
            3'd5: b = 8'd25;
            3'd6: b = 8'd48;
            3'd7: b = 8'd96;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/peak_byte_mux.sv
// Combinational address-to-byte selector over the front frame,
// the status registers and the signature. Multi-byte fields are big-endian.
module peak_byte_mux
    import peak_readout_pkg::*;
(
    input  logic [FRAME_W-1:0] frame_i,
    input  logic [7:0]         addr_i,
    input  logic [7:0]         status_i,
    input  logic [7:0]         drop_i,
    input  logic [7:0]         seq_i,
    output logic [7:0]         byte_o
);

    frame_t     fr;
    logic [7:0] map [64];
    logic [31:0] w;

    assign fr = frame_t'(frame_i);

    // Lay the frame and status out as a flat byte map (addresses 0..36).
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            map[i] = '0;
        end
        w = 32'(fr.counter);
        for (int i = 0; i < 4; i++) begin
            map[i] = w[8*(3-i) +: 8];
        end
        for (int p = 0; p < PEAKS; p++) begin
            map[4+p] = 8'(fr.freqs[p]);
        end
        for (int p = 0; p < PEAKS; p++) begin
            w = 32'(fr.ampls[p]);
            for (int j = 0; j < 4; j++) begin
                map[10+4*p+j] = w[8*(3-j) +: 8];
            end
        end
        map[int'(ADDR_STATUS)] = status_i;
        map[int'(ADDR_DROP)]   = drop_i;
        map[int'(ADDR_SEQ)]    = seq_i;
    end

    // Pick the addressed byte; unmapped addresses read as zero.
    always_comb begin
        byte_o = '0;
        if (addr_i <= ADDR_SEQ) begin
            byte_o = map[addr_i[5:0]];
        end else if (addr_i >= SIG_BASE) begin
            byte_o = sig_byte(addr_i[2:0]);
        end
    end

endmodule

// File: rtl/peak_readout_buffer.sv
// Double-buffered peak frame readout with a software read-lock.
// Optional lock timeout: define PEAK_READOUT_LOCK_TIMEOUT_EN.
module peak_readout_buffer
    import peak_readout_pkg::*;
`ifdef PEAK_READOUT_LOCK_TIMEOUT_EN
#(
    parameter int LOCK_TIMEOUT = 2**20
)
`endif
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        peaks_valid,
    input  logic [TIME_WIDTH-1:0]       peaks_counter,
    input  logic [PEAKS*FREQ_WIDTH-1:0] peaks_freqs,
    input  logic [PEAKS*AMPL_WIDTH-1:0] peaks_ampls,
    input  logic                        chipselect,
    input  logic                        write,
    input  logic [7:0]                  address,
    input  logic [7:0]                  writedata,
    output logic [7:0]                  readdata,
    output logic                        frame_pending
);

    state_t     state_q, state_d;
    frame_t     back_q, back_d;
    frame_t     front_q, front_d;
    frame_t     in_frame;
    logic       pending_q, pending_d;
    logic       overflow_q, overflow_d;
    logic [7:0] drop_q, drop_d;
    logic [7:0] seq_q, seq_d;
    logic [7:0] readdata_q, readdata_d;
    logic       timeout_flag;
    logic       tmo_hit;

    logic       rd, wr;
    logic       xfer, drop_evt, clr;
    logic [7:0] status;
    logic [7:0] mux_byte;
    logic [6:0] unused_wd;

    assign rd = chipselect & ~write;
    assign wr = chipselect & write;

    assign unused_wd = writedata[7:1];

    assign in_frame.counter = peaks_counter;
    assign in_frame.freqs   = peaks_freqs;
    assign in_frame.ampls   = peaks_ampls;

    // Only an unlocked front buffer may be refreshed from the back buffer.
    assign xfer     = (state_q == IDLE) & pending_q;
    assign drop_evt = peaks_valid & pending_q & ~xfer;
    assign clr      = wr & (address == ADDR_STATUS) & writedata[0];

    assign status = {4'b0, timeout_flag, overflow_q,
                     state_q == LOCKED, pending_q};

`ifdef PEAK_READOUT_LOCK_TIMEOUT_EN
    localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d;

    assign tmo_hit = (state_q == LOCKED) &&
                     (tmo_cnt_q == CW'(LOCK_TIMEOUT - 1));

    // Lock age counter: held at zero while idle, counts while locked.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == LOCKED) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        timeout_d = tmo_hit | (timeout_q & ~clr);
    end

    // Timeout counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_flag = timeout_q;
`else
    assign tmo_hit      = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // Lock FSM: a read of byte 0 freezes the front buffer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rd && address == ADDR_LOCK) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if ((rd && address == ADDR_LAST) ||
                    (wr && address == ADDR_ABORT) ||
                    tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture, transfer, status and read-data next state.
    always_comb begin
        back_d     = peaks_valid ? in_frame : back_q;
        front_d    = xfer ? back_q : front_q;
        pending_d  = peaks_valid | (pending_q & ~xfer);
        overflow_d = drop_evt | (overflow_q & ~clr);
        seq_d      = xfer ? seq_q + 8'd1 : seq_q;
        drop_d     = drop_q;
        if (clr) begin
            drop_d = drop_evt ? 8'd1 : 8'd0;
        end else if (drop_evt && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        readdata_d = rd ? mux_byte : readdata_q;
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            back_q     <= '0;
            front_q    <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            seq_q      <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            back_q     <= back_d;
            front_q    <= front_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            seq_q      <= seq_d;
            readdata_q <= readdata_d;
        end
    end

    peak_byte_mux u_mux (
        .frame_i  (front_q),
        .addr_i   (address),
        .status_i (status),
        .drop_i   (drop_q),
        .seq_i    (seq_q),
        .byte_o   (mux_byte)
    );

    assign readdata      = readdata_q;
    assign frame_pending = pending_q;

endmodule

// File: tb/tb_peak_readout_buffer.sv
// Self-checking bench for peak_readout_buffer: directed scenarios
// plus randomized traffic against a frame-level reference model.
module tb_peak_readout_buffer;

    localparam int LT = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         peaks_valid;
    logic [31:0]  peaks_counter;
    logic [47:0]  peaks_freqs;
    logic [143:0] peaks_ampls;
    logic         chipselect;
    logic         write;
    logic [7:0]   address;
    logic [7:0]   writedata;
    logic [7:0]   readdata;
    logic         frame_pending;

    always #10 clk = ~clk;

`ifdef PEAK_READOUT_LOCK_TIMEOUT_EN
    peak_readout_buffer #(.LOCK_TIMEOUT(LT)) dut (
`else
    peak_readout_buffer dut (
`endif
        .clk           (clk),
        .reset         (reset),
        .peaks_valid   (peaks_valid),
        .peaks_counter (peaks_counter),
        .peaks_freqs   (peaks_freqs),
        .peaks_ampls   (peaks_ampls),
        .chipselect    (chipselect),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .frame_pending (frame_pending)
    );

    typedef struct {
        bit [31:0] cnt;
        bit [7:0]  f [6];
        bit [23:0] a [6];
    } mframe_t;

    mframe_t   m_front, m_back, zero_f;
    bit        m_locked, m_pend, m_ovf, m_tmo;
    int        m_drop, m_seq, m_age;
    bit [7:0]  m_rd;
    bit [7:0]  sig [8] = '{8'd42, 8'd53, 8'd84, 8'd71,
                           8'd7, 8'd25, 8'd48, 8'd96};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic bit [7:0] mbyte(input int a);
        bit [31:0] w;
        int p, j;
        if (a <= 3) return 8'(m_front.cnt >> (8*(3-a)));
        if (a <= 9) return m_front.f[a-4];
        if (a <= 33) begin
            p = (a - 10) / 4;
            j = (a - 10) % 4;
            w = {8'h00, m_front.a[p]};
            return 8'(w >> (8*(3-j)));
        end
        if (a == 34) return {4'b0, m_tmo, m_ovf, m_locked, m_pend};
        if (a == 35) return 8'(m_drop);
        if (a == 36) return 8'(m_seq);
        if (a >= 248) return sig[a-248];
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_front  = zero_f;
        m_back   = zero_f;
        m_locked = 0;
        m_pend   = 0;
        m_ovf    = 0;
        m_tmo    = 0;
        m_drop   = 0;
        m_seq    = 0;
        m_age    = 0;
        m_rd     = 0;
    endtask

    // One clock of the buffer's behaviour, evaluated from pre-edge state.
    task automatic model_step(input bit v, input mframe_t nf, input bit cs,
                              input bit we, input int ad, input bit [7:0] wd);
        bit rd, wr, xfer, drop, clr, tmo_now, lock_n;
        rd      = cs && !we;
        wr      = cs && we;
        xfer    = !m_locked && m_pend;
        drop    = v && m_pend && !xfer;
        clr     = wr && ad == 34 && wd[0];
        tmo_now = 0;
        if (rd) m_rd = mbyte(ad);
`ifdef PEAK_READOUT_LOCK_TIMEOUT_EN
        if (m_locked && m_age == LT - 1) tmo_now = 1;
        m_age = m_locked ? m_age + 1 : 0;
`endif
        lock_n = m_locked;
        if (!m_locked) lock_n = rd && ad == 0;
        else if ((rd && ad == 33) || (wr && ad == 255) || tmo_now) lock_n = 0;
        if (xfer) begin
            m_front = m_back;
            m_seq   = (m_seq + 1) % 256;
        end
        if (v) m_back = nf;
        m_pend = v || (m_pend && !xfer);
        if (clr) begin
            m_ovf  = 0;
            m_tmo  = 0;
            m_drop = 0;
        end
        if (drop) begin
            m_ovf  = 1;
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
        if (tmo_now) m_tmo = 1;
        m_locked = lock_n;
    endtask

    task automatic step(input bit v, input mframe_t f, input bit cs,
                        input bit we, input bit [7:0] ad, input bit [7:0] wd);
        @(negedge clk);
        peaks_valid   = v;
        peaks_counter = f.cnt;
        for (int p = 0; p < 6; p++) begin
            peaks_freqs[8*p +: 8]   = f.f[p];
            peaks_ampls[24*p +: 24] = f.a[p];
        end
        chipselect = cs;
        write      = we;
        address    = ad;
        writedata  = wd;
        model_step(v, f, cs, we, int'(ad), wd);
        @(posedge clk);
        #1;
        chk("rdata", readdata, m_rd);
        chk("pend", frame_pending, m_pend);
    endtask

    task automatic idle();
        step(0, zero_f, 0, 0, 8'd0, 8'd0);
    endtask

    task automatic push(input mframe_t f);
        step(1, f, 0, 0, 8'd0, 8'd0);
    endtask

    task automatic rd_at(input bit [7:0] ad);
        step(0, zero_f, 1, 0, ad, 8'd0);
    endtask

    task automatic wr_at(input bit [7:0] ad, input bit [7:0] d);
        step(0, zero_f, 1, 1, ad, d);
    endtask

    function automatic mframe_t rand_frame();
        mframe_t f;
        f.cnt = $urandom;
        for (int p = 0; p < 6; p++) begin
            f.f[p] = 8'($urandom);
            f.a[p] = 24'($urandom);
        end
        return f;
    endfunction

    mframe_t f1, f2, fa, fb;
    bit [7:0] exp13 [14] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAB,
                             8'hCD, 8'hEF};

    initial begin
        reset         = 1'b1;
        peaks_valid   = 1'b0;
        peaks_counter = '0;
        peaks_freqs   = '0;
        peaks_ampls   = '0;
        chipselect    = 1'b0;
        write         = 1'b0;
        address       = '0;
        writedata     = '0;
        model_reset();
        #1;
        chk("rst_rdata", readdata, 8'h00);
        chk("rst_pend", frame_pending, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single frame, then byte readout.
        f1 = zero_f;
        f1.cnt  = 32'h01020304;
        f1.f[0] = 8'h11;
        f1.a[0] = 24'hABCDEF;
        push(f1);
        idle();
        rd_at(8'd34);
        chk("st_first", readdata, 8'h00);
        rd_at(8'd36);
        chk("seq_first", readdata, 8'd1);
        for (int a = 0; a < 14; a++) begin
            rd_at(8'(a));
            chk($sformatf("f1_b%0d", a), readdata, exp13[a]);
        end

        // Locked: new frame must not tear the front buffer.
        f2 = rand_frame();
        f2.cnt = 32'h00000055;
        push(f2);
        for (int a = 1; a <= 33; a++) begin
            rd_at(8'(a));
        end
        rd_at(8'd3);
        chk("lock_intact", readdata, 8'h04);
        rd_at(8'd33);
        idle();
        rd_at(8'd3);
        chk("f2_b3", readdata, 8'h55);
        rd_at(8'd36);
        chk("seq_second", readdata, 8'd2);

        // Overflow while locked, then status clear and abort.
        rd_at(8'd0);
        repeat (3) push(rand_frame());
        rd_at(8'd34);
        chk("st_ovf", readdata, 8'h07);
        rd_at(8'd35);
        chk("drop_two", readdata, 8'd2);
        wr_at(8'd34, 8'h01);
        rd_at(8'd34);
        chk("st_clr", readdata, 8'h03);
        rd_at(8'd35);
        chk("drop_clr", readdata, 8'd0);
        wr_at(8'd255, 8'hA5);
        rd_at(8'd34);
        chk("abort_lk", readdata[1], 1'b0);
        idle();
        idle();

        // New frame coincident with a transfer.
        fa = rand_frame();
        fb = rand_frame();
        push(fa);
        push(fb);
        chk("coinc_pend", frame_pending, 1'b1);
        rd_at(8'd3);
        chk("coinc_front", readdata, fa.cnt[7:0]);
        rd_at(8'd34);
        chk("coinc_ovf", readdata[2], 1'b0);
        idle();

        // Signature and unmapped address.
        for (int i = 0; i < 8; i++) begin
            rd_at(8'(248 + i));
            chk($sformatf("sig%0d", i), readdata, sig[i]);
        end
        rd_at(8'd100);
        chk("unmapped", readdata, 8'h00);

`ifdef PEAK_READOUT_LOCK_TIMEOUT_EN
        rd_at(8'd0);
        repeat (LT) idle();
        rd_at(8'd34);
        chk("tmo_unlk", readdata[1], 1'b0);
        chk("tmo_flag", readdata[3], 1'b1);
        wr_at(8'd34, 8'h01);
`endif

        // Asynchronous reset in the middle of a lock.
        push(rand_frame());
        rd_at(8'd0);
        push(rand_frame());
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_rd", readdata, 8'h00);
        chk("mid_rst_pend", frame_pending, 1'b0);
        peaks_valid = 1'b0;
        chipselect  = 1'b0;
        write       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd_at(8'd34);
        chk("post_rst_st", readdata, 8'h00);
        rd_at(8'd3);
        chk("post_rst_front", readdata, 8'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bit       v, cs, we;
            bit [7:0] ad, wd;
            int       r;
            v  = ($urandom_range(0, 9) < 3);
            cs = ($urandom_range(0, 9) < 6);
            we = cs && ($urandom_range(0, 3) == 0);
            r  = $urandom_range(0, 9);
            case (r)
                0: ad = 8'd0;
                1: ad = 8'd33;
                2: ad = 8'd34;
                3: ad = 8'd35;
                4: ad = 8'd36;
                5: ad = 8'd255;
                6: ad = 8'(248 + $urandom_range(0, 7));
                default: ad = 8'($urandom_range(0, 40));
            endcase
            wd = 8'($urandom);
            step(v, rand_frame(), cs, we, ad, wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
